// File: rtl/axis_prbs_frame_gen.sv
// axis_prbs_frame_gen: AXI4-Stream PRBS frame generator for the Aurora TX user interface
// Ports: USER_CLK/RESET (async, active-high); CHANNEL_UP aborts and reseeds when low;
// ENABLE permits new frames; AXI4_S_IP_TREADY sink ready; AXI4_S_OP_* stream outputs;
// FRAME_COUNT frames accepted; STALL_COUNT backpressure cycles when AXIS_GEN_STALL_CNT_EN is defined.
module axis_prbs_frame_gen #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int          MAX_LEN_W   = 4,
    parameter int          IDLE_CYCLES = 2,
    parameter logic [15:0] SEED        = 16'hABCD
) (
    input  logic                  USER_CLK,
    input  logic                  RESET,
    input  logic                  CHANNEL_UP,
    input  logic                  ENABLE,
    input  logic                  AXI4_S_IP_TREADY,
    output logic [DATA_WIDTH-1:0] AXI4_S_OP_TDATA,
    output logic [KEEP_WIDTH-1:0] AXI4_S_OP_TKEEP,
    output logic                  AXI4_S_OP_TLAST,
    output logic                  AXI4_S_OP_TVALID,
    output logic [15:0]           FRAME_COUNT,
    output logic [15:0]           STALL_COUNT
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam logic [KEEP_WIDTH-1:0] ONES = {KEEP_WIDTH{1'b1}};
    localparam logic [15:0] GAP_N = 16'(IDLE_CYCLES);
    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d, lfsr_nxt;
    logic [MAX_LEN_W-1:0]  cnt_q, cnt_d;
    logic [15:0]           gap_q, gap_d;
    logic [KEEP_WIDTH-1:0] keep_last_q, keep_last_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    // cnt_q holds the words still to send after the current one
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        keep_last_d = keep_last_q;
        tkeep_d     = tkeep_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        frame_cnt_d = frame_cnt_q;
        if (!CHANNEL_UP) begin
            state_d     = IDLE;
            lfsr_d      = SEED;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            tkeep_d     = '0;
            tdata_d     = '0;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (ENABLE) begin
                    state_d     = SEND;
                    tvalid_d    = 1'b1;
                    tdata_d     = {2{lfsr_q}};
                    cnt_d       = lfsr_q[MAX_LEN_W-1:0];
                    // lastbytes = lfsr[5:4]+1 lanes, packed from the MSB lane down
                    keep_last_d = ~((ONES >> 1) >> lfsr_q[5:4]);
                    tlast_d     = lfsr_q[MAX_LEN_W-1:0] == '0;
                    tkeep_d     = tlast_d ? keep_last_d : ONES;
                end
                SEND: if (AXI4_S_IP_TREADY) begin
                    lfsr_d = lfsr_nxt;
                    if (tlast_q) begin
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        gap_d       = '0;
                        state_d     = (IDLE_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt_d   = cnt_q - MAX_LEN_W'(1);
                        tdata_d = {2{lfsr_nxt}};
                        tlast_d = cnt_q == MAX_LEN_W'(1);
                        tkeep_d = tlast_d ? keep_last_q : ONES;
                    end
                end
                GAP: begin
                    gap_d   = gap_q + 16'd1;
                    state_d = (gap_q == GAP_N - 16'd1) ? IDLE : GAP;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            cnt_q       <= '0;
            gap_q       <= '0;
            keep_last_q <= '0;
            tkeep_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            keep_last_q <= keep_last_d;
            tkeep_q     <= tkeep_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
`ifdef AXIS_GEN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    always_comb begin
        stall_d = stall_q;
        if (!CHANNEL_UP)
            stall_d = '0;
        else if (tvalid_q && !AXI4_S_IP_TREADY && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end
    assign STALL_COUNT = stall_q;
`else
    assign STALL_COUNT = 16'h0000;
`endif
    assign AXI4_S_OP_TDATA  = tdata_q;
    assign AXI4_S_OP_TKEEP  = tkeep_q;
    assign AXI4_S_OP_TLAST  = tlast_q;
    assign AXI4_S_OP_TVALID = tvalid_q;
    assign FRAME_COUNT      = frame_cnt_q;
endmodule

// File: tb/tb_axis_prbs_frame_gen.sv
// tb_axis_prbs_frame_gen: directed self-checking bench for axis_prbs_frame_gen
module tb_axis_prbs_frame_gen;
    localparam logic [15:0] SEED = 16'hABCD;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, chan_up, enable, tready;
    logic [31:0] tdata;
    logic [3:0] tkeep;
    logic tlast, tvalid;
    logic [15:0] fcnt, scnt;
    logic chan_up_b, tready_b, enable_b;
    logic [31:0] tdata_b;
    logic [3:0] tkeep_b;
    logic tlast_b, tvalid_b;
    logic [15:0] fcnt_b, scnt_b;
    int total = 0, bad = 0;

    axis_prbs_frame_gen dut (
        .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(chan_up), .ENABLE(enable),
        .AXI4_S_IP_TREADY(tready), .AXI4_S_OP_TDATA(tdata), .AXI4_S_OP_TKEEP(tkeep),
        .AXI4_S_OP_TLAST(tlast), .AXI4_S_OP_TVALID(tvalid), .FRAME_COUNT(fcnt), .STALL_COUNT(scnt)
    );
    axis_prbs_frame_gen #(.IDLE_CYCLES(0)) dut_b (
        .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(chan_up_b), .ENABLE(enable_b),
        .AXI4_S_IP_TREADY(tready_b), .AXI4_S_OP_TDATA(tdata_b), .AXI4_S_OP_TKEEP(tkeep_b),
        .AXI4_S_OP_TLAST(tlast_b), .AXI4_S_OP_TVALID(tvalid_b), .FRAME_COUNT(fcnt_b), .STALL_COUNT(scnt_b)
    );

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    endfunction
    function automatic logic [3:0] kfor(input logic [1:0] b);
        case (b)
            2'd0: return 4'b1000;
            2'd1: return 4'b1100;
            2'd2: return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    // waits for the next accepted beat; returns at the negedge before its handshake edge
    task automatic wait_beat(output logic [31:0] d, output logic [3:0] k, output logic l, output bit ok);
        ok = 1'b0; d = '0; k = '0; l = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (tvalid && tready) begin
                d = tdata; k = tkeep; l = tlast; ok = 1'b1;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL beat_timeout: no accepted beat within 400 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; chan_up = 1'b0; enable = 1'b0; tready = 1'b0;
        chan_up_b = 1'b0; enable_b = 1'b1; tready_b = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", tvalid); end
        total++; if (tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b want 0", tlast); end
        total++; if (tkeep !== 4'h0) begin bad++; $display("FAIL rst_tkeep: got %h want 0", tkeep); end
        total++; if (tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata: got %h want 0", tdata); end
        total++; if (fcnt !== 16'h0) begin bad++; $display("FAIL rst_fcnt: got %0d want 0", fcnt); end
        total++; if (scnt !== 16'h0) begin bad++; $display("FAIL rst_scnt: got %0d want 0", scnt); end
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        logic [31:0] d; logic [3:0] k; logic l; bit ok;
        logic [15:0] m;
        m = SEED;
        chan_up = 1'b1; enable = 1'b1; tready = 1'b1;
        for (int w = 1; w <= 14; w++) begin
            wait_beat(d, k, l, ok);
            if (w == 1) begin
                total++; if (d !== 32'hABCDABCD) begin bad++; $display("FAIL first_w1: got %h want abcdabcd", d); end
            end
            if (w == 2) begin
                total++; if (d !== 32'h579A579A) begin bad++; $display("FAIL first_w2: got %h want 579a579a", d); end
            end
            total++;
            if ({d, k, l} !== {m, m, (w == 14) ? 4'b1000 : 4'hF, w == 14}) begin
                bad++; $display("FAIL first_word%0d: got %h/%b/%b want %h/%b/%b", w, d, k, l,
                                {m, m}, (w == 14) ? 4'b1000 : 4'hF, w == 14);
            end
            m = nxt(m);
        end
        @(negedge clk);
        total++; if (fcnt !== 16'd1) begin bad++; $display("FAIL first_fcnt: got %0d want 1", fcnt); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL first_gap_tvalid: got %b want 0", tvalid); end
    endtask

    task automatic test_random_tready();
        logic [15:0] m; int wi, len, frames;
        logic [3:0] kl, ek; logic el;
        chan_up = 1'b0; tready = 1'b1;
        @(negedge clk);
        chan_up = 1'b1; enable = 1'b1;
        m = SEED; wi = 0; len = 1; frames = 0; kl = '0; el = 1'b0; ek = '0;
        for (int c = 0; c < 60000 && frames < 1000; c++) begin
            @(negedge clk);
            if (tvalid) begin
                if (wi == 0) begin len = int'(m[3:0]) + 1; kl = kfor(m[5:4]); end
                el = (wi == len - 1);
                ek = el ? kl : 4'hF;
                total++;
                if ({tdata, tkeep, tlast} !== {m, m, ek, el}) begin
                    bad++; $display("FAIL rand_frame%0d_word%0d: got %h/%b/%b want %h/%b/%b",
                                    frames, wi, tdata, tkeep, tlast, {m, m}, ek, el);
                end
            end
            tready = ($urandom_range(0, 3) != 0);
            if (tvalid && tready) begin
                m = nxt(m);
                wi = el ? 0 : wi + 1;
                if (el) frames++;
            end
        end
        tready = 1'b1;
        total++; if (frames != 1000) begin bad++; $display("FAIL rand_frames: got %0d want 1000", frames); end
        @(negedge clk);
        total++; if (fcnt !== 16'd1000) begin bad++; $display("FAIL rand_fcnt: got %0d want 1000", fcnt); end
    endtask

    task automatic test_back_to_back();
        int gaps, zeros;
        bit after_last;
        gaps = 0; zeros = 0; after_last = 1'b0;
        chan_up_b = 1'b1;
        for (int c = 0; c < 200 && gaps < 3; c++) begin
            @(negedge clk);
            if (after_last) begin
                if (!tvalid_b) zeros++;
                else begin
                    total++;
                    if (zeros !== 1) begin bad++; $display("FAIL b2b_gap%0d: got %0d idle cycles want 1", gaps, zeros); end
                    gaps++; after_last = 1'b0;
                end
            end else if (tvalid_b && tlast_b) begin
                after_last = 1'b1; zeros = 0;
            end
        end
        total++; if (gaps != 3) begin bad++; $display("FAIL b2b_timeout: got %0d gaps want 3", gaps); end
        chan_up_b = 1'b0;
    endtask

    task automatic test_chan_down();
        logic [31:0] d; logic [3:0] k; logic l; bit ok;
        chan_up = 1'b0; tready = 1'b1;
        @(negedge clk);
        total++; if (fcnt !== 16'd0) begin bad++; $display("FAIL chdn_fcnt_clear: got %0d want 0", fcnt); end
        chan_up = 1'b1; enable = 1'b1;
        for (int w = 1; w <= 5; w++) wait_beat(d, k, l, ok);
        chan_up = 1'b0;
        @(negedge clk);
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL chdn_tvalid: got %b want 0", tvalid); end
        total++; if (tlast !== 1'b0) begin bad++; $display("FAIL chdn_tlast: got %b want 0", tlast); end
        total++; if (fcnt !== 16'd0) begin bad++; $display("FAIL chdn_fcnt: got %0d want 0", fcnt); end
        chan_up = 1'b1;
        wait_beat(d, k, l, ok);
        total++; if (d !== 32'hABCDABCD) begin bad++; $display("FAIL chdn_restart: got %h want abcdabcd", d); end
    endtask

    task automatic test_enable_drop();
        logic [31:0] d; logic [3:0] k; logic l; bit ok, seen;
        logic [15:0] m; int words;
        chan_up = 1'b0; tready = 1'b1;
        @(negedge clk);
        chan_up = 1'b1; enable = 1'b1;
        m = SEED; words = 0; l = 1'b0; k = '0; ok = 1'b1;
        while (!l && ok && words < 20) begin
            wait_beat(d, k, l, ok);
            words++;
            if (words == 3) enable = 1'b0;
            m = nxt(m);
        end
        total++; if (words != 14) begin bad++; $display("FAIL en_len: got %0d want 14", words); end
        total++; if (k !== 4'b1000) begin bad++; $display("FAIL en_last_keep: got %b want 1000", k); end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tvalid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL en_no_new_frame: got tvalid while disabled"); end
        enable = 1'b1;
        wait_beat(d, k, l, ok);
        total++; if (d !== {m, m}) begin bad++; $display("FAIL en_resume: got %h want %h", d, {m, m}); end
    endtask

    task automatic test_stall();
        bit found;
        logic [15:0] exp_s;
`ifdef AXIS_GEN_STALL_CNT_EN
        exp_s = 16'd20;
`else
        exp_s = 16'd0;
`endif
        chan_up = 1'b0; tready = 1'b0;
        @(negedge clk);
        chan_up = 1'b1; enable = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (tvalid) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL stall_start: tvalid never rose"); end
        repeat (20) @(negedge clk);
        total++; if (scnt !== exp_s) begin bad++; $display("FAIL stall_count: got %0d want %0d", scnt, exp_s); end
        total++; if (tdata !== 32'hABCDABCD) begin bad++; $display("FAIL stall_hold: got %h want abcdabcd", tdata); end
        tready = 1'b1;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (tvalid) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL arst_setup: tvalid never rose"); end
        #2 rst = 1'b1;
        #1;
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL arst_tvalid: got %b want 0", tvalid); end
        total++; if (tdata !== 32'h0) begin bad++; $display("FAIL arst_tdata: got %h want 0", tdata); end
        total++; if (tkeep !== 4'h0) begin bad++; $display("FAIL arst_tkeep: got %h want 0", tkeep); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_random_tready();
        test_back_to_back();
        test_chan_down();
        test_enable_drop();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
